// File: rtl/branch_pc_predictor.sv
// branch_pc_predictor: fetch next-PC selection, ID-stage prediction check, redirect and branch statistics
// Ports: clk/rst (async active-low), en (global enable), stall (IF/ID hold)
//        btb_hit/btb_taken/btb_target  : BTB lookup for the current fetch PC
//        ID_branch/ID_taken/ID_branch_addr : resolved outcome of the instruction in ID
//        pc/IF_pred_taken              : fetch PC and the prediction applied to it
//        ID_pc                         : PC of the instruction held in ID
//        misprediction/flush/redirect_pc : wrong-prediction strobe, IF squash, corrected fetch address
//        branch_count/mispredict_count : saturating statistics
module branch_pc_predictor #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    PREDICT_SIZE = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0,
    parameter int                    PC_INC       = 4,
    parameter int                    CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    stall,
    input  logic                    btb_hit,
    input  logic [PREDICT_SIZE-1:0] btb_taken,
    input  logic [DATA_WIDTH-1:0]   btb_target,
    input  logic                    ID_branch,
    input  logic                    ID_taken,
    input  logic [DATA_WIDTH-1:0]   ID_branch_addr,
    output logic [DATA_WIDTH-1:0]   pc,
    output logic                    IF_pred_taken,
    output logic [DATA_WIDTH-1:0]   ID_pc,
    output logic                    misprediction,
    output logic                    flush,
    output logic [DATA_WIDTH-1:0]   redirect_pc,
    output logic [CNT_WIDTH-1:0]    branch_count,
    output logic [CNT_WIDTH-1:0]    mispredict_count
);
    localparam logic [DATA_WIDTH-1:0] PC_INC_W = DATA_WIDTH'(PC_INC);

    logic [DATA_WIDTH-1:0] pc_q, pc_d, id_pc_q, id_pc_d, id_pred_next_q, id_pred_next_d;
    logic                  id_valid_q, id_valid_d, id_pred_taken_q, id_pred_taken_d;
    logic [CNT_WIDTH-1:0]  branch_count_q, branch_count_d, mispredict_count_q, mispredict_count_d;
    logic [DATA_WIDTH-1:0] if_next, actual_next;
    logic                  resolve, mispredict, load;
    logic                  btb_taken_unused;

    // Only the counter MSB carries the direction; lower bits are hysteresis for the BTB itself.
    assign btb_taken_unused = ^btb_taken;

    assign IF_pred_taken = btb_hit & btb_taken[PREDICT_SIZE-1];
    assign if_next       = IF_pred_taken ? btb_target : pc_q + PC_INC_W;
    // A stalled ID instruction is not resolved; its operands may not be ready yet.
    assign resolve       = en & ~stall & id_valid_q;
    assign actual_next   = (ID_branch & ID_taken) ? ID_branch_addr : id_pc_q + PC_INC_W;
    // A non-branch predicted taken is a BTB alias and must fall through.
    assign mispredict    = resolve & (ID_branch ? (actual_next != id_pred_next_q) : id_pred_taken_q);
    assign load          = en & ~mispredict & ~stall;

    assign pc               = pc_q;
    assign ID_pc            = id_pc_q;
    assign misprediction    = mispredict;
    assign flush            = mispredict;
    assign redirect_pc      = mispredict ? actual_next : '0;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

    always_comb begin
        // Misprediction overrides stall for the fetch PC only.
        pc_d               = !en ? pc_q : mispredict ? actual_next : stall ? pc_q : if_next;
        // The squashed wrong-path slot enters ID as a bubble.
        id_valid_d         = mispredict ? 1'b0 : load ? 1'b1 : id_valid_q;
        id_pc_d            = load ? pc_q : id_pc_q;
        id_pred_taken_d    = load ? IF_pred_taken : id_pred_taken_q;
        id_pred_next_d     = load ? if_next : id_pred_next_q;
        branch_count_d     = (resolve & ID_branch & ~&branch_count_q) ?
                             branch_count_q + CNT_WIDTH'(1) : branch_count_q;
        mispredict_count_d = (mispredict & ~&mispredict_count_q) ?
                             mispredict_count_q + CNT_WIDTH'(1) : mispredict_count_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q               <= RESET_PC;
            id_valid_q         <= 1'b0;
            id_pc_q            <= '0;
            id_pred_taken_q    <= 1'b0;
            id_pred_next_q     <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            pc_q               <= pc_d;
            id_valid_q         <= id_valid_d;
            id_pc_q            <= id_pc_d;
            id_pred_taken_q    <= id_pred_taken_d;
            id_pred_next_q     <= id_pred_next_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end
endmodule
